// File: rtl/muxn_pkg.sv
// Shared types and helpers for the pipelined N-way result mux.
package muxn_pkg;

  localparam int MAX_STAGES = 4;

  // Per-stage side-band bits; data travels as a separate WIDTH-bit vector.
  typedef struct packed {
    logic valid;
    logic err;
  } stage_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/muxn_pipe_stage.sv
// One register stage of the muxn_pipe datapath: data plus valid/err flags,
// async active-high reset, synchronous clear over enable.
module pipe_stage
  import muxn_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] data_i,
  input  stage_t           flags_i,
  output logic [WIDTH-1:0] data_o,
  output stage_t           flags_o
);

  logic [WIDTH-1:0] data_q, data_d;
  stage_t           flags_q, flags_d;

  always_comb begin
    data_d  = data_q;
    flags_d = flags_q;
    if (clr) begin
      data_d  = '0;
      flags_d = '0;
    end else if (en) begin
      data_d  = data_i;
      flags_d = flags_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      flags_q <= '0;
    end else begin
      data_q  <= data_d;
      flags_q <= flags_d;
    end
  end

  assign data_o  = data_q;
  assign flags_o = flags_q;

endmodule

// File: rtl/muxn_pipe.sv
// N-input WIDTH-bit mux followed by STAGES register stages with stall/flush.
// Build option MUXN_SEL_CHECK_EN: out-of-range sel yields zero data and a pipelined sel_err.
module muxn_pipe
  import muxn_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int N      = 4,
  parameter  int STAGES = 1,
  localparam int SELW   = sel_width(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] d,
  input  logic [SELW-1:0]    sel,
  input  logic               valid_in,
  input  logic               en,
  input  logic               clr,
  output logic [WIDTH-1:0]   y,
  output logic               valid_out,
  output logic               sel_err
);

  if (N < 2 || STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_param
    $error("muxn_pipe: unsupported N or STAGES");
  end

  logic [WIDTH-1:0] m;
  logic             sel_oor;

  always_comb begin
`ifdef MUXN_SEL_CHECK_EN
    m = '0;
`else
    m = d[WIDTH-1:0];
`endif
    for (int k = 0; k < N; k++) begin
      if (sel == SELW'(k)) m = d[k*WIDTH +: WIDTH];
    end
  end

`ifdef MUXN_SEL_CHECK_EN
  assign sel_oor = (int'(sel) >= N);

  always @(posedge clk) begin
    if (!reset && en && valid_in) assert (!sel_oor);
  end
`else
  assign sel_oor = 1'b0;
`endif

  // Index 0 is the combinational mux output; index STAGES is the last register.
  logic [WIDTH-1:0] data_s  [STAGES+1];
  stage_t           flags_s [STAGES+1];

  assign data_s[0]  = m;
  assign flags_s[0] = '{valid: valid_in, err: sel_oor};

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .en      (en),
      .data_i  (data_s[i]),
      .flags_i (flags_s[i]),
      .data_o  (data_s[i+1]),
      .flags_o (flags_s[i+1])
    );
  end

  assign y         = data_s[STAGES];
  assign valid_out = flags_s[STAGES].valid;
  assign sel_err   = flags_s[STAGES].err;

endmodule

// File: tb/tb_muxn_pipe.sv
// Scoreboard bench for muxn_pipe (WIDTH=8, N=4, STAGES=2) plus an N=3 instance for out-of-range sel.
module tb_muxn_pipe;

  localparam int W  = 8;
  localparam int ST = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  d = 32'h44332211;
  logic [1:0]   sel;
  logic         valid_in, en, clr;
  logic [W-1:0] y;
  logic         valid_out, sel_err;

  logic [23:0]  d3 = 24'h332211;
  logic [1:0]   sel3;
  logic         vin3, en3, clr3;
  logic [W-1:0] y3;
  logic         valid3, err3;

  always #5 clk = ~clk;

  muxn_pipe #(.WIDTH(W), .N(4), .STAGES(ST)) dut (
    .clk(clk), .reset(reset), .d(d), .sel(sel), .valid_in(valid_in),
    .en(en), .clr(clr), .y(y), .valid_out(valid_out), .sel_err(sel_err)
  );

  muxn_pipe #(.WIDTH(W), .N(3), .STAGES(ST)) dut3 (
    .clk(clk), .reset(reset), .d(d3), .sel(sel3), .valid_in(vin3),
    .en(en3), .clr(clr3), .y(y3), .valid_out(valid3), .sel_err(err3)
  );

  typedef struct {
    int           tag;
    logic [W-1:0] y;
    logic         v;
    logic         err;
  } exp_t;

  exp_t sb[$];
  int   en_edges = 0;
  int   tests = 0;
  int   fails = 0;
  logic [W-1:0] exp_tab [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (!reset && en && !clr) en_edges <= en_edges + 1;
  end

  // An entry captured on enabled edge t is visible after enabled edge t+ST-1.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() > 0 && sb[0].tag + ST - 1 == en_edges) begin
      e = sb.pop_front();
      chk("sb_y", {24'h0, y}, {24'h0, e.y});
      chk("sb_valid", {31'h0, valid_out}, {31'h0, e.v});
      chk("sb_err", {31'h0, sel_err}, {31'h0, e.err});
    end
  end

  task automatic step(input logic e, input logic c, input logic v, input logic [1:0] s);
    exp_t x;
    en = e; clr = c; valid_in = v; sel = s;
    if (c) sb.delete();
    else if (e) begin
      x.tag = en_edges + 1; x.y = exp_tab[s]; x.v = v; x.err = 1'b0;
      sb.push_back(x);
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; valid_in = 1'b0; sel = 2'd0;
    en3 = 1'b0; clr3 = 1'b0; vin3 = 1'b0; sel3 = 2'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_y", {24'h0, y}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_err", {31'h0, sel_err}, 32'h0);
    reset = 1'b0;

    // Basic select, then bubbles
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 2);
    step(1, 0, 1, 3);
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    // Capture 33 and stall: bubble 22 sits at the output
    step(1, 0, 1, 2);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 3);
      chk("stall_y", {24'h0, y}, 32'h22);
      chk("stall_valid", {31'h0, valid_out}, 32'h0);
    end
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);

    // Flush with en=1; sel=3 on the flush cycle must never appear
    step(1, 1, 1, 3);
    chk("flush_y", {24'h0, y}, 32'h0);
    chk("flush_valid", {31'h0, valid_out}, 32'h0);
    chk("flush_err", {31'h0, sel_err}, 32'h0);
    step(1, 0, 1, 2);
    step(1, 0, 1, 0);
    step(1, 0, 1, 1);

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1;
    chk("arst_y", {24'h0, y}, 32'h0);
    chk("arst_valid", {31'h0, valid_out}, 32'h0);
    chk("arst_err", {31'h0, sel_err}, 32'h0);
    sb.delete();
    reset = 1'b0;

    step(1, 0, 1, 3);
    step(1, 0, 0, 1);
    en = 1'b1; valid_in = 1'b0;
    @(posedge clk); #1;
    en = 1'b0;
    @(negedge clk); #1;
    chk("sb_drained", sb.size(), 0);

    // Out-of-range select on the N=3 instance
    en3 = 1'b1; vin3 = 1'b1; sel3 = 2'd2;
    @(posedge clk); #1;
    sel3 = 2'd3;
`ifdef MUXN_SEL_CHECK_EN
    vin3 = 1'b0;
`endif
    @(posedge clk); #1;
    chk("n3_y", {24'h0, y3}, 32'h33);
    chk("n3_valid", {31'h0, valid3}, 32'h1);
    chk("n3_err", {31'h0, err3}, 32'h0);
    @(posedge clk); #1;
    en3 = 1'b0;
`ifdef MUXN_SEL_CHECK_EN
    chk("oor_y", {24'h0, y3}, 32'h0);
    chk("oor_err", {31'h0, err3}, 32'h1);
    chk("oor_valid", {31'h0, valid3}, 32'h0);
`else
    chk("oor_y", {24'h0, y3}, 32'h11);
    chk("oor_err", {31'h0, err3}, 32'h0);
    chk("oor_valid", {31'h0, valid3}, 32'h1);
`endif
    @(posedge clk); #1;
    chk("oor_hold_y", {24'h0, y3}, 32'h33 & 32'h0 | (`ifdef MUXN_SEL_CHECK_EN 32'h0 `else 32'h11 `endif));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
